mips_bus_bridge: RTL and testbench

MIPS_BUS_BRIDGE -- requirements
Module: mips_bus_bridge

---
 rtl/mips_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_mips_bus_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_bridge.sv
// Single-outstanding bridge from the MIPS data port to data memory and N_DEV
// memory-mapped device windows, with per-target wait states and fault reporting.
module mips_bus_bridge #(
   parameter int                  N_DEV    = 2,
   parameter logic [31:0]         DM_LIMIT = 32'h0000_3000,
   parameter logic [N_DEV*32-1:0] DEV_BASE = {32'h7F10, 32'h7F00},
   parameter logic [N_DEV*32-1:0] DEV_SIZE = {32'hC, 32'hC},
   parameter logic [N_DEV*4-1:0]  DEV_WAIT = {4'd0, 4'd0},
   parameter logic [3:0]          DM_WAIT  = 4'd0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req,
   input  logic [31:0]           i_addr,
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_byteen,
   output logic                  o_ready,
   output logic [31:0]           o_rdata,
   output logic                  o_err,
   output logic                  o_busy,
   output logic [7:0]            o_err_cnt,
   output logic [31:0]           o_dm_addr,
   output logic [31:0]           o_dm_wdata,
   output logic [3:0]            o_dm_byteen,
   input  logic [31:0]           i_dm_rdata,
   output logic [31:0]           o_dev_addr,
   output logic [31:0]           o_dev_wdata,
   output logic [N_DEV-1:0]      o_dev_sel,
   output logic [N_DEV-1:0]      o_dev_we,
   input  logic [32*N_DEV-1:0]   i_dev_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
   logic [3:0]  byteen_q, cnt_q;
   logic [2:0]  slot_q;
   logic        is_dm_q, err_q;
   logic [7:0]  err_cnt_q;

   logic        dec_dm, dec_hit, dec_fault;
   logic [2:0]  dec_slot;
   logic [3:0]  dec_wait;
   logic        last, wr;

   // Descending scan so the lowest-index matching window wins.
   always_comb begin
      dec_dm   = i_addr < DM_LIMIT;
      dec_hit  = 1'b0;
      dec_slot = '0;
      dec_wait = DM_WAIT;
      for (int k = N_DEV-1; k >= 0; k--) begin
         if (i_addr >= DEV_BASE[32*k +: 32] &&
             (i_addr - DEV_BASE[32*k +: 32]) < DEV_SIZE[32*k +: 32]) begin
            dec_hit  = 1'b1;
            dec_slot = 3'(k);
            dec_wait = DEV_WAIT[4*k +: 4];
         end
      end
      if (dec_dm) dec_wait = DM_WAIT;
      dec_fault = !dec_dm && (!dec_hit || i_addr[1:0] != 2'b00 ||
                              (i_byteen != 4'h0 && i_byteen != 4'hF));
   end

   assign last = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign wr   = byteen_q != 4'h0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_req) state_d = dec_fault ? RESP : ACCESS;
         ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      rdata_d = '0;
      if (is_dm_q) rdata_d = i_dm_rdata;
      else begin
         for (int k = 0; k < N_DEV; k++)
            if (slot_q == 3'(k)) rdata_d = i_dev_rdata[32*k +: 32];
      end
      if (wr) rdata_d = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         byteen_q  <= '0;
         cnt_q     <= '0;
         slot_q    <= '0;
         is_dm_q   <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         if (state_q == IDLE && i_req) begin
            addr_q   <= i_addr;
            wdata_q  <= i_wdata;
            byteen_q <= i_byteen;
            cnt_q    <= dec_wait;
            slot_q   <= dec_slot;
            is_dm_q  <= dec_dm;
            err_q    <= dec_fault;
            rdata_q  <= '0;
         end else if (state_q == ACCESS) begin
            if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
            else               rdata_q <= rdata_d;
         end
         if (state_q == RESP && err_q && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   // Selects and strobes are purely combinational from state so an async reset drops them at once.
   always_comb begin
      o_dev_sel   = '0;
      o_dev_we    = '0;
      o_dm_byteen = '0;
      if (state_q == ACCESS) begin
         if (is_dm_q) begin
            if (last) o_dm_byteen = byteen_q;
         end else begin
            for (int k = 0; k < N_DEV; k++) begin
               o_dev_sel[k] = slot_q == 3'(k);
               o_dev_we[k]  = (slot_q == 3'(k)) && last && wr;
            end
         end
      end
   end

   assign o_ready     = state_q == RESP;
   assign o_err       = (state_q == RESP) && err_q;
   assign o_busy      = state_q != IDLE;
   assign o_rdata     = rdata_q;
   assign o_err_cnt   = err_cnt_q;
   assign o_dm_addr   = addr_q;
   assign o_dev_addr  = addr_q;
   assign o_dm_wdata  = wdata_q;
   assign o_dev_wdata = wdata_q;

endmodule

// File: tb/tb_mips_bus_bridge.sv
// Bench for mips_bus_bridge: directed vector table, back-to-back and reset-abort
// sequences, then randomized traffic against a behavioural address-map model.
module tb_mips_bus_bridge;

   localparam int          N_DEV = 2;
   localparam logic [31:0] BASES [2] = '{32'h7F00, 32'h7F10};
   localparam logic [31:0] SIZES [2] = '{32'hC, 32'hC};
   localparam int          WAITS [2] = '{0, 3};
   localparam int          DMW       = 0;

   logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
   logic [31:0] addr = '0, wdata = '0, dm_rdata = '0;
   logic [3:0]  be = '0;
   logic [63:0] dev_rdata = '0;
   logic        o_ready, o_err, o_busy;
   logic [31:0] o_rdata, o_dm_addr, o_dm_wdata, o_dev_addr, o_dev_wdata;
   logic [7:0]  o_err_cnt;
   logic [3:0]  o_dm_byteen;
   logic [1:0]  o_dev_sel, o_dev_we;

   mips_bus_bridge #(
      .N_DEV(N_DEV), .DM_LIMIT(32'h3000),
      .DEV_BASE({32'h7F10, 32'h7F00}), .DEV_SIZE({32'hC, 32'hC}),
      .DEV_WAIT({4'd3, 4'd0}), .DM_WAIT(4'd0)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_wdata(wdata),
      .i_byteen(be), .o_ready(o_ready), .o_rdata(o_rdata), .o_err(o_err),
      .o_busy(o_busy), .o_err_cnt(o_err_cnt), .o_dm_addr(o_dm_addr),
      .o_dm_wdata(o_dm_wdata), .o_dm_byteen(o_dm_byteen), .i_dm_rdata(dm_rdata),
      .o_dev_addr(o_dev_addr), .o_dev_wdata(o_dev_wdata), .o_dev_sel(o_dev_sel),
      .o_dev_we(o_dev_we), .i_dev_rdata(dev_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr, wdata;
      logic [3:0]  be;
      logic [31:0] dm_rd, d0_rd, d1_rd;
      logic        err;
      int          lat;
      logic [31:0] rdata;
      logic [1:0]  sel, we;
      logic [3:0]  dmbe;
   } vec_t;

   vec_t tbl [13];
   int   n_pass = 0, n_tot = 0, exp_ecnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Address map rules evaluated directly: DM below the limit, else first window containing addr.
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                                  input logic [31:0] dmr, input logic [31:0] d0, input logic [31:0] d1);
      vec_t v;
      int   hit = -1;
      v.addr = a; v.wdata = wd; v.be = b; v.dm_rd = dmr; v.d0_rd = d0; v.d1_rd = d1;
      v.err = 1'b0; v.rdata = '0; v.sel = '0; v.we = '0; v.dmbe = '0;
      if (a < 32'h3000) begin
         v.lat  = DMW + 2;
         v.dmbe = b;
         if (b == 4'h0) v.rdata = dmr;
      end else begin
         for (int k = 0; k < N_DEV; k++)
            if (hit < 0 && longint'(a) >= longint'(BASES[k]) &&
                longint'(a) < longint'(BASES[k]) + longint'(SIZES[k])) hit = k;
         if (hit < 0 || a[1:0] != 2'b00 || (b != 4'h0 && b != 4'hF)) begin
            v.err = 1'b1;
            v.lat = 1;
         end else begin
            v.lat = WAITS[hit] + 2;
            v.sel = (hit == 0) ? 2'b01 : 2'b10;
            if (b != 4'h0) v.we = v.sel;
            else           v.rdata = (hit == 0) ? d0 : d1;
         end
      end
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int         sel_cnt = 0, we_cnt = 0, we_cyc = -1, dmbe_cnt = 0, dmbe_cyc = -1, rdy = -1;
      logic [1:0] sel_or = '0, we_or = '0;
      logic [3:0] dmbe_or = '0;
      logic       addr_ok = 1'b1, err_v = 1'b0;
      logic [31:0] rd_v = '0;
      @(negedge clk);
      chk("idle_before", 32'(o_busy), 32'd0);
      req = 1'b1; addr = v.addr; wdata = v.wdata; be = v.be;
      dm_rdata = v.dm_rd; dev_rdata = {v.d1_rd, v.d0_rd};
      @(posedge clk);
      for (int n = 1; n <= 40 && rdy < 0; n++) begin
         @(negedge clk);
         req = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom);
         if (n == 1) chk("wdata_latched", o_dev_wdata, v.wdata);
         if (o_dev_sel != 0) begin
            sel_cnt++; sel_or |= o_dev_sel;
            if (o_dev_addr !== v.addr) addr_ok = 1'b0;
         end
         if (o_dev_we != 0) begin we_cnt++; we_or |= o_dev_we; we_cyc = n; end
         if (o_dm_byteen != 0) begin
            dmbe_cnt++; dmbe_or |= o_dm_byteen; dmbe_cyc = n;
            if (o_dm_addr !== v.addr || o_dm_wdata !== v.wdata) addr_ok = 1'b0;
         end
         if (o_ready) begin rdy = n; err_v = o_err; rd_v = o_rdata; end
      end
      chk("latency", 32'(rdy), 32'(v.lat));
      chk("err", 32'(err_v), 32'(v.err));
      chk("rdata", rd_v, v.rdata);
      chk("sel_mask", 32'(sel_or), 32'(v.sel));
      chk("sel_cycles", 32'(sel_cnt), (v.sel != 0) ? 32'(v.lat - 1) : 32'd0);
      chk("we_mask", 32'(we_or), 32'(v.we));
      chk("we_cycles", 32'(we_cnt), (v.we != 0) ? 32'd1 : 32'd0);
      if (v.we != 0) chk("we_final_cycle", 32'(we_cyc), 32'(v.lat - 1));
      chk("dm_be", 32'(dmbe_or), 32'(v.dmbe));
      chk("dm_be_cycles", 32'(dmbe_cnt), (v.dmbe != 0) ? 32'd1 : 32'd0);
      if (v.dmbe != 0) chk("dm_be_final_cycle", 32'(dmbe_cyc), 32'(v.lat - 1));
      chk("addr_held", 32'(addr_ok), 32'd1);
      if (v.err) exp_ecnt = (exp_ecnt == 255) ? 255 : exp_ecnt + 1;
      @(negedge clk);
      chk("err_cnt", 32'(o_err_cnt), 32'(exp_ecnt));
      chk("busy_after", 32'(o_busy), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(o_ready), 32'd0);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_rdata"}, o_rdata, 32'd0);
      chk({tag, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
      chk({tag, "_sel"}, 32'(o_dev_sel), 32'd0);
      chk({tag, "_we"}, 32'(o_dev_we), 32'd0);
      chk({tag, "_dm_be"}, 32'(o_dm_byteen), 32'd0);
      chk({tag, "_addr"}, o_dm_addr, 32'd0);
      chk({tag, "_wdata"}, o_dev_wdata, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      //           addr          wdata         be    dm_rd         d0_rd         d1_rd         err  lat rdata         sel    we     dmbe
      tbl[0]  = '{32'h0000_0100, 32'h0,        4'h0, 32'hDEAD_BEEF, 32'h0,       32'h0,        1'b0, 2, 32'hDEAD_BEEF, 2'b00, 2'b00, 4'h0};
      tbl[1]  = '{32'h0000_0200, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 32'h0,      32'h0,        1'b0, 2, 32'h0,        2'b00, 2'b00, 4'h3};
      tbl[2]  = '{32'h0000_7F14, 32'hA1B2_C3D4, 4'hF, 32'h0,        32'h0,       32'h5555_5555, 1'b0, 5, 32'h0,        2'b10, 2'b10, 4'h0};
      tbl[3]  = '{32'h0000_7F04, 32'h0,        4'h0, 32'h0,        32'hCAFE_0000, 32'h0BAD_0BAD, 1'b0, 2, 32'hCAFE_0000, 2'b01, 2'b00, 4'h0};
      tbl[4]  = '{32'h0000_7F18, 32'h0,        4'h0, 32'h0,        32'h0BAD_0BAD, 32'h1111_2222, 1'b0, 5, 32'h1111_2222, 2'b10, 2'b00, 4'h0};
      tbl[5]  = '{32'h0000_7F08, 32'h0F0F_0F0F, 4'hF, 32'h0,       32'h7777_7777, 32'h0,        1'b0, 2, 32'h0,        2'b01, 2'b01, 4'h0};
      tbl[6]  = '{32'h0000_7F30, 32'h0,        4'h0, 32'h9999_9999, 32'h8888_8888, 32'h6666_6666, 1'b1, 1, 32'h0,     2'b00, 2'b00, 4'h0};
      tbl[7]  = '{32'h0000_7F02, 32'hFFFF_0000, 4'hF, 32'h0,       32'h0,       32'h0,        1'b1, 1, 32'h0,        2'b00, 2'b00, 4'h0};
      tbl[8]  = '{32'h0000_7F14, 32'h0000_FFFF, 4'h3, 32'h0,       32'h0,       32'h0,        1'b1, 1, 32'h0,        2'b00, 2'b00, 4'h0};
      tbl[9]  = '{32'h0000_7F0C, 32'h0,        4'h0, 32'h0,        32'h4444_4444, 32'h0,        1'b1, 1, 32'h0,        2'b00, 2'b00, 4'h0};
      tbl[10] = '{32'h0000_2FFC, 32'h0,        4'h0, 32'h0BAD_F00D, 32'h0,       32'h0,        1'b0, 2, 32'h0BAD_F00D, 2'b00, 2'b00, 4'h0};
      tbl[11] = '{32'h0000_3000, 32'h0,        4'h0, 32'h1234_0000, 32'h0,       32'h0,        1'b1, 1, 32'h0,        2'b00, 2'b00, 4'h0};
      tbl[12] = '{32'h0000_7F02, 32'h0,        4'h0, 32'h0,        32'h3333_3333, 32'h0,        1'b1, 1, 32'h0,        2'b00, 2'b00, 4'h0};

      // power-on reset
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) run_txn(tbl[i]);

      // i_req held high: changes during ACCESS are ignored, next request taken right after RESP
      begin
         int r1 = -1, r2 = -1;
         logic e1 = 1'b0, e2 = 1'b0;
         logic [31:0] d1 = '0;
         @(negedge clk);
         req = 1'b1; addr = 32'h7F18; be = 4'h0; dev_rdata = {32'hA5A5_0001, 32'h1111_2222};
         @(posedge clk);
         for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            addr = 32'h7F30;
            if (n == 7) req = 1'b0;
            if (n == 2) chk("b2b_addr_latched", o_dev_addr, 32'h7F18);
            if (n == 6) chk("b2b_idle_gap", 32'(o_busy), 32'd0);
            if (o_ready && r1 < 0) begin r1 = n; e1 = o_err; d1 = o_rdata; end
            else if (o_ready && r2 < 0) begin r2 = n; e2 = o_err; end
         end
         exp_ecnt++;
         chk("b2b_first_lat", 32'(r1), 32'd5);
         chk("b2b_first_err", 32'(e1), 32'd0);
         chk("b2b_first_rdata", d1, 32'hA5A5_0001);
         chk("b2b_second_lat", 32'(r2), 32'd7);
         chk("b2b_second_err", 32'(e2), 32'd1);
         chk("b2b_err_cnt", 32'(o_err_cnt), 32'(exp_ecnt));
      end

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         logic [3:0]  b;
         case ($urandom_range(0, 2))
            0:       a = $urandom_range(0, 32'h2FFF);
            1:       a = 32'h7EF0 + $urandom_range(0, 63);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 2))
            0:       b = 4'h0;
            1:       b = 4'hF;
            default: b = 4'($urandom);
         endcase
         run_txn(model(a, $urandom, b, $urandom, $urandom, $urandom));
      end

      // drive the fault counter into saturation
      for (int i = 0; i < 260; i++)
         run_txn(model(32'h7F30, $urandom, 4'h0, $urandom, $urandom, $urandom));
      chk("err_cnt_saturated", 32'(o_err_cnt), 32'hFF);

      // reset two cycles into a 3-wait device write
      begin
         logic bad = 1'b0;
         @(negedge clk);
         req = 1'b1; addr = 32'h7F14; wdata = 32'hFEED_FACE; be = 4'hF;
         @(posedge clk);
         @(negedge clk);
         req = 1'b0;
         if (o_dev_we != 0) bad = 1'b1;
         @(negedge clk);
         if (o_dev_we != 0) bad = 1'b1;
         chk("abort_in_access", 32'(o_dev_sel), 32'h2);
         rst_n = 1'b0;
         #1;
         chk_all_zero("abort");
         for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1'b1;
            if (o_dev_we != 0 || o_ready) bad = 1'b1;
         end
         chk("abort_no_strobe_or_ready", 32'(bad), 32'd0);
         exp_ecnt = 0;
         run_txn(tbl[2]);
         run_txn(tbl[6]);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
